// File: rtl/adc_frame_capture_if.sv
// Bundle of control, ADC sample and FIFO write signals
// for the ADC frame capture block.
interface adc_frame_capture_if;
  logic        start;
  logic        abort;
  logic [7:0]  adc_din;
  logic        adc_valid;
  logic [7:0]  decim;
  logic        trig_en;
  logic [7:0]  trig_level;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [15:0] fifo_din;
  logic        busy;
  logic        done;
  logic        overflow;

  modport master (
    output start, abort, adc_din, adc_valid,
    output decim, trig_en, trig_level, fifo_full,
    input  fifo_wr_en, fifo_din, busy, done, overflow
  );

  modport slave (
    input  start, abort, adc_din, adc_valid,
    input  decim, trig_en, trig_level, fifo_full,
    output fifo_wr_en, fifo_din, busy, done, overflow
  );
endinterface

// File: rtl/adc_frame_capture.sv
// Decimates, level-triggers and packs 8-bit ADC samples
// into 16-bit words, one frame of FRAME_WORDS per start.
module adc_frame_capture #(
  parameter int FRAME_WORDS = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  adc_frame_capture_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_CAP,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(FRAME_WORDS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_dmax;
  logic [7:0]       r_dcnt;
  logic             r_trig_en;
  logic [7:0]       r_lvl;
  logic [7:0]       r_prev;
  logic [7:0]       r_lo;
  logic             r_phase;
  logic [CNT_W-1:0] r_wcnt;
  logic             r_wr_en;
  logic [15:0]      r_dout;
  logic             r_ovf;

  logic w_run;
  logic w_acc;
  logic w_trig;
  logic w_cap_acc;
  logic w_word;
  logic w_last;
  logic w_start_ok;

  // Sample qualification and next-state decode
  always_comb begin
    w_run      = (r_state == S_ARM) || (r_state == S_CAP);
    w_acc      = w_run && bus.adc_valid && (r_dcnt == 8'd0);
    w_trig     = (r_state == S_ARM) && r_trig_en && w_acc &&
                 (r_prev < r_lvl) && (bus.adc_din >= r_lvl);
    w_cap_acc  = (r_state == S_CAP) && w_acc;
    w_word     = w_cap_acc && r_phase;
    w_last     = w_word && (r_wcnt == LAST);
    w_start_ok = bus.start &&
                 ((r_state == S_IDLE) || (r_state == S_DONE));
    w_next     = r_state;
    unique case (r_state)
      S_IDLE: if (bus.start) w_next = S_ARM;
      S_ARM:  if (!r_trig_en || w_trig) w_next = S_CAP;
      S_CAP:  if (w_last) w_next = S_DONE;
      S_DONE: if (bus.start) w_next = S_ARM;
      default: w_next = S_IDLE;
    endcase
    if (bus.abort) w_next = S_IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Decimation, trigger history, packing and FIFO write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dmax    <= '0;
      r_dcnt    <= '0;
      r_trig_en <= 1'b0;
      r_lvl     <= '0;
      r_prev    <= '0;
      r_lo      <= '0;
      r_phase   <= 1'b0;
      r_wcnt    <= '0;
      r_wr_en   <= 1'b0;
      r_dout    <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (bus.abort) begin
        r_phase <= 1'b0;
        r_lo    <= '0;
      end else if (w_start_ok) begin
        r_dmax    <= (bus.decim == 8'd0) ? 8'd0
                                         : bus.decim - 8'd1;
        r_trig_en <= bus.trig_en;
        r_lvl     <= bus.trig_level;
        r_dcnt    <= '0;
        r_wcnt    <= '0;
        r_phase   <= 1'b0;
        r_ovf     <= 1'b0;
        r_prev    <= 8'hFF;
      end else begin
        if (w_run && bus.adc_valid)
          r_dcnt <= (r_dcnt >= r_dmax) ? 8'd0
                                       : r_dcnt + 8'd1;
        if (w_acc) r_prev <= bus.adc_din;
        if (w_trig) begin
          r_lo    <= bus.adc_din;
          r_phase <= 1'b1;
        end
        if (w_cap_acc && !r_phase) begin
          r_lo    <= bus.adc_din;
          r_phase <= 1'b1;
        end
        if (w_word) begin
          r_phase <= 1'b0;
          r_wcnt  <= r_wcnt + CNT_W'(1);
          if (bus.fifo_full) begin
            r_ovf <= 1'b1;
          end else begin
            r_wr_en <= 1'b1;
            r_dout  <= {bus.adc_din, r_lo};
          end
        end
      end
    end
  end

  assign bus.fifo_wr_en = r_wr_en;
  assign bus.fifo_din   = r_dout;
  assign bus.busy       = (r_state == S_ARM) ||
                          (r_state == S_CAP);
  assign bus.done       = (r_state == S_DONE);
  assign bus.overflow   = r_ovf;

endmodule

// File: tb/tb_adc_frame_capture.sv
// Self-checking bench for adc_frame_capture with a
// sample-list reference model and randomized frames.
module tb_adc_frame_capture;

  localparam int FW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [15:0] q_got[$];
  logic [15:0] exp_q[$];

  adc_frame_capture_if bus();

  adc_frame_capture #(
    .FRAME_WORDS(FW),
    .CNT_W(16)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Collect every FIFO write away from the active edge
  always @(negedge clk)
    if (bus.fifo_wr_en === 1'b1) q_got.push_back(bus.fifo_din);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int d, input bit te,
                          input logic [7:0] lvl);
    bus.decim      = 8'(d);
    bus.trig_en    = te;
    bus.trig_level = lvl;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
  endtask

  task automatic feed(input logic [7:0] s);
    bus.adc_din   = s;
    bus.adc_valid = 1'b1;
    tick();
    bus.adc_valid = 1'b0;
  endtask

  task automatic go_idle();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    tick();
    tick();
    q_got.delete();
  endtask

  // Expected words from the list of valid samples after start
  function automatic void build_exp(
    input logic [7:0] s[$], input int d,
    input bit te, input logic [7:0] lvl);
    logic [7:0] kept[$];
    logic [7:0] data[$];
    int de;
    int k;
    logic [7:0] prev;
    exp_q.delete();
    de = (d == 0) ? 1 : d;
    for (int i = 0; i < s.size(); i++)
      if (i % de == 0) kept.push_back(s[i]);
    k = te ? -1 : 0;
    prev = 8'hFF;
    if (te)
      for (int i = 0; i < kept.size(); i++) begin
        if (k < 0 && prev < lvl && kept[i] >= lvl) k = i;
        prev = kept[i];
      end
    if (k >= 0)
      for (int i = k; i < kept.size(); i++)
        data.push_back(kept[i]);
    for (int j = 0; j < FW; j++)
      if (2 * j + 1 < data.size())
        exp_q.push_back({data[2*j+1], data[2*j]});
  endfunction

  task automatic test_reset();
    n_chk++;
    if (bus.fifo_wr_en !== 1'b0 || bus.fifo_din !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_fifo: wr_en=%b din=%h want 0 0000",
               bus.fifo_wr_en, bus.fifo_din);
    end
    n_chk++;
    if ({bus.busy, bus.done, bus.overflow} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_status: busy/done/ovf=%b want 000",
               {bus.busy, bus.done, bus.overflow});
    end
  endtask

  task automatic test_free_run();
    logic [15:0] want[4] = '{16'h0201, 16'h0403,
                             16'h0605, 16'h0807};
    q_got.delete();
    do_start(1, 1'b0, 8'h00);
    for (int i = 1; i <= 8; i++) feed(8'(i));
    tick();
    n_chk++;
    if (q_got.size() != 4) begin
      n_fail++;
      $display("FAIL free_count: got %0d want 4", q_got.size());
    end
    for (int i = 0; i < 4 && i < q_got.size(); i++) begin
      n_chk++;
      if (q_got[i] !== want[i]) begin
        n_fail++;
        $display("FAIL free_word%0d: got %h want %h",
                 i, q_got[i], want[i]);
      end
    end
    n_chk++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL free_done: done=%b busy=%b want 1 0",
               bus.done, bus.busy);
    end
    go_idle();
  endtask

  task automatic test_decim();
    logic [15:0] want[4] = '{16'h0300, 16'h0906,
                             16'h0F0C, 16'h1512};
    do_start(3, 1'b0, 8'h00);
    for (int i = 0; i < 24; i++) feed(8'(i));
    tick();
    n_chk++;
    if (q_got.size() != 4) begin
      n_fail++;
      $display("FAIL decim_count: got %0d want 4", q_got.size());
    end
    for (int i = 0; i < 4 && i < q_got.size(); i++) begin
      n_chk++;
      if (q_got[i] !== want[i]) begin
        n_fail++;
        $display("FAIL decim_word%0d: got %h want %h",
                 i, q_got[i], want[i]);
      end
    end
    go_idle();
  endtask

  task automatic test_trigger();
    logic [7:0] s[$] = '{8'h90, 8'h70, 8'h7F, 8'h80, 8'h81,
                         8'h82, 8'h83, 8'h84, 8'h85, 8'h86,
                         8'h87};
    do_start(1, 1'b1, 8'h80);
    for (int i = 0; i < 3; i++) feed(s[i]);
    n_chk++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL trig_armed: busy=%b want 1", bus.busy);
    end
    for (int i = 3; i < s.size(); i++) feed(s[i]);
    tick();
    n_chk++;
    if (q_got.size() != 4 || q_got[0] !== 16'h8180) begin
      n_fail++;
      $display("FAIL trig_first: n=%0d w0=%h want 4 8180",
               q_got.size(),
               q_got.size() > 0 ? q_got[0] : 16'hxxxx);
    end
    n_chk++;
    if (q_got.size() == 4 && q_got[3] !== 16'h8786) begin
      n_fail++;
      $display("FAIL trig_last: got %h want 8786", q_got[3]);
    end
    go_idle();
    do_start(1, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) feed(8'(i * 16));
    tick();
    n_chk++;
    if (q_got.size() != 0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL trig_zero: n=%0d busy=%b want 0 1",
               q_got.size(), bus.busy);
    end
    go_idle();
  endtask

  task automatic test_full();
    logic [15:0] want[3] = '{16'h0201, 16'h0605, 16'h0807};
    do_start(1, 1'b0, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      bus.fifo_full = (i == 4 || i == 5);
      feed(8'(i));
    end
    bus.fifo_full = 1'b0;
    tick();
    n_chk++;
    if (q_got.size() != 3) begin
      n_fail++;
      $display("FAIL full_count: got %0d want 3", q_got.size());
    end
    for (int i = 0; i < 3 && i < q_got.size(); i++) begin
      n_chk++;
      if (q_got[i] !== want[i]) begin
        n_fail++;
        $display("FAIL full_word%0d: got %h want %h",
                 i, q_got[i], want[i]);
      end
    end
    n_chk++;
    if (bus.overflow !== 1'b1 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL full_flags: ovf=%b done=%b want 1 1",
               bus.overflow, bus.done);
    end
    do_start(1, 1'b0, 8'h00);
    n_chk++;
    if (bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_clear: ovf=%b want 0", bus.overflow);
    end
    go_idle();
  endtask

  task automatic test_abort();
    logic [15:0] want[4] = '{16'h0201, 16'h0403,
                             16'h0605, 16'h0807};
    do_start(1, 1'b0, 8'h00);
    feed(8'h11);
    bus.abort = 1'b1;
    feed(8'h22);
    bus.abort = 1'b0;
    tick();
    tick();
    n_chk++;
    if (q_got.size() != 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_pair: n=%0d busy=%b want 0 0",
               q_got.size(), bus.busy);
    end
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tick();
    n_chk++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_start: busy=%b done=%b want 0 0",
               bus.busy, bus.done);
    end
    do_start(1, 1'b0, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      bus.start = (i == 4);
      feed(8'(i));
    end
    bus.start = 1'b0;
    tick();
    n_chk++;
    if (q_got.size() != 4 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL cap_start: n=%0d done=%b want 4 1",
               q_got.size(), bus.done);
    end
    for (int i = 0; i < 4 && i < q_got.size(); i++) begin
      n_chk++;
      if (q_got[i] !== want[i]) begin
        n_fail++;
        $display("FAIL cap_start_word%0d: got %h want %h",
                 i, q_got[i], want[i]);
      end
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    logic [15:0] want[4] = '{16'h0201, 16'h0403,
                             16'h0605, 16'h0807};
    do_start(1, 1'b0, 8'h00);
    feed(8'h11);
    feed(8'h22);
    feed(8'h33);
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.fifo_wr_en, bus.fifo_din, bus.busy,
         bus.done, bus.overflow} !== 20'h0) begin
      n_fail++;
      $display("FAIL rst_mid: wr=%b din=%h busy=%b want 0 0000 0",
               bus.fifo_wr_en, bus.fifo_din, bus.busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
    q_got.delete();
    do_start(0, 1'b0, 8'h00);
    for (int i = 1; i <= 8; i++) feed(8'(i));
    tick();
    n_chk++;
    if (q_got.size() != 4) begin
      n_fail++;
      $display("FAIL rst_d0_count: got %0d want 4", q_got.size());
    end
    for (int i = 0; i < 4 && i < q_got.size(); i++) begin
      n_chk++;
      if (q_got[i] !== want[i]) begin
        n_fail++;
        $display("FAIL rst_d0_word%0d: got %h want %h",
                 i, q_got[i], want[i]);
      end
    end
    go_idle();
  endtask

  task automatic test_random();
    logic [7:0] s[$];
    int d;
    bit te;
    logic [7:0] lvl;
    bit exp_done;
    for (int it = 0; it < 24; it++) begin
      s.delete();
      d   = $urandom_range(0, 4);
      te  = 1'($urandom_range(0, 1));
      lvl = ($urandom_range(0, 7) == 0) ? 8'h00
                                        : 8'($urandom_range(1, 255));
      for (int i = 0; i < 8 * ((d == 0) ? 1 : d) + 40; i++)
        s.push_back(8'($urandom_range(0, 255)));
      build_exp(s, d, te, lvl);
      do_start(d, te, lvl);
      foreach (s[i]) begin
        while ($urandom_range(0, 3) == 0) tick();
        feed(s[i]);
      end
      tick();
      tick();
      exp_done = (exp_q.size() == FW);
      n_chk++;
      if (q_got.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL rnd%0d_count: got %0d want %0d",
                 it, q_got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < q_got.size(); i++) begin
        n_chk++;
        if (q_got[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rnd%0d_word%0d: got %h want %h",
                   it, i, q_got[i], exp_q[i]);
        end
      end
      n_chk++;
      if (bus.done !== exp_done || bus.busy !== !exp_done) begin
        n_fail++;
        $display("FAIL rnd%0d_state: done=%b busy=%b want %b %b",
                 it, bus.done, bus.busy, exp_done, !exp_done);
      end
      go_idle();
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.adc_din    = '0;
    bus.adc_valid  = 1'b0;
    bus.decim      = '0;
    bus.trig_en    = 1'b0;
    bus.trig_level = '0;
    bus.fifo_full  = 1'b0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_free_run();
    test_decim();
    test_trigger();
    test_full();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_frame_capture.md
Name: adc_frame_capture

Overview:
Upstream feeder for the UART dump path. Takes 8-bit AD9481 samples, optionally decimates and level-triggers them, and packs pairs into 16-bit words. Writes one frame of FRAME_WORDS words into the dual-clock FIFO that the UART stage drains and prints as ASCII. Single-clock block on the ADC capture clock.

Parameters:
FRAME_WORDS, 1024, 16-bit words written per frame (2*FRAME_WORDS samples); range 2..65535
CNT_W, 16, width of the word counter; must satisfy 2^CNT_W > FRAME_WORDS

Ports:
clk  in  1  ADC capture clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; arms a new frame capture
abort  in  1  single-cycle pulse; cancels capture and returns to IDLE
adc_din  in  8  ADC sample, unsigned offset binary
adc_valid  in  1  adc_din valid this cycle
decim  in  8  keep 1 of every decim valid samples; 0 is treated as 1; latched on start
trig_en  in  1  1 = wait for rising level crossing; 0 = free-run; latched on start
trig_level  in  8  trigger threshold; latched on start
fifo_full  in  1  FIFO write-full flag
fifo_wr_en  out  1  FIFO write strobe, one cycle per word
fifo_din  out  16  packed word {second sample, first sample}
busy  out  1  high in ARM or CAPTURE
done  out  1  high in DONE
overflow  out  1  sticky: a word was dropped because fifo_full was high

Behaviour:
- Reset: state=IDLE; fifo_wr_en=0, fifo_din=0, busy=0, done=0, overflow=0; all counters, the held low byte and the previous-sample register are 0.
- States:
  - IDLE: start -> ARM.
  - ARM: trig_en=0 -> CAPTURE on the next cycle. trig_en=1 -> wait for a rising crossing, then -> CAPTURE.
  - CAPTURE: -> DONE when the FRAME_WORDS-th word is issued.
  - DONE: start -> ARM.
- start is ignored in ARM and CAPTURE.
- abort in any state -> IDLE next cycle. It discards any held low byte, suppresses any pending write and leaves overflow unchanged. If abort and start occur in the same cycle, abort wins.
- On accepted start:
  - latch decim, trig_en and trig_level
  - clear the decimation counter, word counter, pair phase and overflow
  - clear the previous-sample register to 0xFF, so there is no false trigger on the first sample
- Decimation: the counter advances only on adc_valid and wraps at max(decim,1)-1. A sample is "accepted" on an adc_valid cycle where the counter is 0, so the first valid sample after start is accepted. Decimation runs in both ARM and CAPTURE.
- Trigger: evaluated only on accepted samples in ARM.
  - Crossing = previous accepted sample < trig_level and current sample >= trig_level.
  - The crossing sample is the first sample captured: it becomes the low byte.
  - Every accepted sample updates the previous-sample register.
  - trig_level=0 never triggers, because nothing is < 0; the block stays in ARM until abort.
- Packing: within CAPTURE, accepted samples alternate phase. The even-phase sample is held as the low byte. The odd-phase sample forms {odd, even}.
- Write: fifo_wr_en=1 and fifo_din valid in the cycle after the odd sample is accepted. The strobe is exactly one cycle wide. fifo_din holds its value until the next word.
- Full handling: if fifo_full=1 in the cycle a word would be written, suppress fifo_wr_en and set overflow=1. The word still counts toward FRAME_WORDS, so frame length in time is deterministic.
- Completion: the word counter increments on every issued or dropped word. When it reaches FRAME_WORDS, state becomes DONE in the same cycle as the last fifo_wr_en. Samples after that are ignored.
- Reset mid-capture: immediate return to reset values; no partial write.

Test Plan:
1. Free-run: decim=1, trig_en=0, FRAME_WORDS=4, adc_din=0x01..0x08 on consecutive valid cycles -> 4 strobes with fifo_din 0x0201, 0x0403, 0x0605, 0x0807; done=1 after the last strobe; busy=0.
2. Decimation: decim=3, ramp 0x00..0x17 every cycle -> words 0x0300, 0x0906, 0x0F0C, 0x1512.
3. Trigger: trig_en=1, trig_level=0x80, samples 0x90,0x70,0x7F,0x80,0x81,… -> no trigger on 0x90 (prev=0xFF); trigger on 0x80; first word 0x8180.
4. Full: fifo_full=1 during word 2 of 4 -> 3 strobes only; overflow=1; done after 4 word slots; next start clears overflow.
5. Abort and start: abort after the first sample of a pair -> IDLE, no strobe; start in the same cycle as abort -> remains IDLE; start during CAPTURE -> ignored, frame completes normally.
6. Reset: rst_n low mid-CAPTURE with a held byte -> all outputs 0 asynchronously; after release, start with decim=0 behaves as decim=1.
